// File: rtl/codec_dsp_port_if.sv
// Parallel-side bundle of the codec DSP port: received pairs, tx pair handshake, status pulses.
// master = audio datapath side, slave = codec_dsp_port.
interface codec_dsp_port_if #(
  parameter int BITSIZE = 24
) ();
  logic [BITSIZE-1:0] rx_left;
  logic [BITSIZE-1:0] rx_right;
  logic               rx_valid;
  logic [BITSIZE-1:0] tx_left;
  logic [BITSIZE-1:0] tx_right;
  logic               tx_valid;
  logic               tx_ready;
  logic               underrun;
  logic               sync_err;

  modport master (
    input  rx_left, rx_right, rx_valid, tx_ready, underrun, sync_err,
    output tx_left, tx_right, tx_valid
  );

  modport slave (
    output rx_left, rx_right, rx_valid, tx_ready, underrun, sync_err,
    input  tx_left, tx_right, tx_valid
  );
endinterface

// File: rtl/codec_dsp_port.sv
// DSP mode B serial audio port (codec is bus master) <-> parallel stereo words in the clk domain.
// Optional CODEC_LOOPBACK_EN: frame-end tx load takes the pair just received instead of the tx buffer.
module codec_dsp_port #(
  parameter int BITSIZE     = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            bclk,
  input  logic            lrclk,
  input  logic            adcdat,
  output logic            dacdat,
  codec_dsp_port_if.slave bus
);
  localparam int FB = 2 * BITSIZE;
  localparam int CW = $clog2(FB + 1);
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [CW-1:0] LAST = CW'(FB);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, SHIFT, GAP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SS-1:0]   bclk_s, lrclk_s, adcdat_s;
  logic [FB-1:0]   rx_sh, tx_sh, load_word;
  logic            bclk_rise, bclk_fall, lr, ad, frame_start, frame_end;

  // Edges from the last two stages; lrclk/adcdat taken from the same stage as the new bclk level.
  assign bclk_rise   = bclk_s[SS-2] & ~bclk_s[SS-1];
  assign bclk_fall   = ~bclk_s[SS-2] & bclk_s[SS-1];
  assign lr          = lrclk_s[SS-2];
  assign ad          = adcdat_s[SS-2];
  assign frame_start = bclk_rise & lr;
  assign frame_end   = (state == SHIFT) && (cnt == LAST);

`ifdef CODEC_LOOPBACK_EN
  assign bus.tx_ready = 1'b0;

  always_comb begin
    load_word = {bus.rx_left, bus.rx_right};
    if (frame_end) load_word = rx_sh;
  end
`else
  logic [FB-1:0] tx_buf;
  logic          buf_full;

  assign bus.tx_ready = ~buf_full;

  always_comb begin
    load_word = '0;
    if (buf_full) load_word = tx_buf;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_s       <= '0;
      lrclk_s      <= '0;
      adcdat_s     <= '0;
      state        <= IDLE;
      cnt          <= '0;
      rx_sh        <= '0;
      tx_sh        <= '0;
      dacdat       <= 1'b0;
      bus.rx_left  <= '0;
      bus.rx_right <= '0;
      bus.rx_valid <= 1'b0;
      bus.underrun <= 1'b0;
      bus.sync_err <= 1'b0;
`ifndef CODEC_LOOPBACK_EN
      tx_buf       <= '0;
      buf_full     <= 1'b0;
`endif
    end else begin
      bclk_s       <= {bclk_s[SS-2:0], bclk};
      lrclk_s      <= {lrclk_s[SS-2:0], lrclk};
      adcdat_s     <= {adcdat_s[SS-2:0], adcdat};
      bus.rx_valid <= 1'b0;
      bus.underrun <= 1'b0;
      bus.sync_err <= 1'b0;

      if (!enable) begin
        state  <= IDLE;
        cnt    <= '0;
        rx_sh  <= '0;
        dacdat <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= WAIT_SYNC;
          WAIT_SYNC, GAP: begin
            if (frame_start) begin
              rx_sh <= {{(FB-1){1'b0}}, ad};
              cnt   <= ONE;
              state <= SHIFT;
            end
          end
          SHIFT: begin
            if (frame_end) begin
              bus.rx_left  <= rx_sh[FB-1:BITSIZE];
              bus.rx_right <= rx_sh[BITSIZE-1:0];
              bus.rx_valid <= 1'b1;
              tx_sh        <= load_word;
              dacdat       <= load_word[FB-1];
`ifndef CODEC_LOOPBACK_EN
              if (buf_full) buf_full <= 1'b0;
              else          bus.underrun <= 1'b1;
`endif
              cnt   <= '0;
              state <= GAP;
            end else if (frame_start && cnt != '0) begin
              // Abandon the frame: this edge becomes bit 0 and tx restarts (no underrun report).
              bus.sync_err <= 1'b1;
              rx_sh        <= {{(FB-1){1'b0}}, ad};
              cnt          <= ONE;
              tx_sh        <= load_word;
              dacdat       <= load_word[FB-1];
`ifndef CODEC_LOOPBACK_EN
              buf_full     <= 1'b0;
`endif
            end else begin
              if (bclk_rise) begin
                rx_sh <= {rx_sh[FB-2:0], ad};
                cnt   <= cnt + ONE;
              end
              if (bclk_fall) begin
                tx_sh  <= {tx_sh[FB-2:0], 1'b0};
                dacdat <= tx_sh[FB-2];
              end
            end
          end
          default: state <= IDLE;
        endcase
      end

`ifndef CODEC_LOOPBACK_EN
      // A same-cycle frame-end load has already seen the buffer empty; the new pair waits for the next frame.
      if (bus.tx_valid && !buf_full) begin
        tx_buf   <= {bus.tx_left, bus.tx_right};
        buf_full <= 1'b1;
      end
`endif
    end
  end
endmodule
